// File: rtl/dmac_multi.sv
// Multi-channel DMA controller: NCH programmable channels sharing one HLD/HLDA bus-master engine.
// Build with DMAC_ROTATE_PRIO_EN defined for rotating channel priority (fixed lowest-index otherwise).
module dmac_multi #(
   parameter int NCH = 4,
   parameter int AW  = 16,
   parameter int DW  = 8,
   parameter int CHW = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REGW,
   input  logic [CHW-1:0]  CHSEL,
   input  logic [1:0]      REGSEL,
   input  logic [AW-1:0]   Setup,
   input  logic [NCH-1:0]  DREQ,
   output logic [NCH-1:0]  DACK,
   output logic            HLD,
   input  logic            HLDA,
   input  logic            RDY,
   output logic            MEMR,
   output logic            MEMW,
   output logic            IOR,
   output logic            IOW,
   output logic            EOP,
   output logic [AW-1:0]   Addrbus,
   input  logic [DW-1:0]   Data_in,
   output logic [DW-1:0]   Data_out,
   output logic            BUSY
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_HLDA, S_ADDR, S_STROBE, S_UPDATE} state_t;

   state_t         state, state_nxt;
   logic [4:0]     mode  [NCH];
   logic [AW-1:0]  count [NCH];
   logic [AW-1:0]  addr  [NCH];
   logic [CHW-1:0] ch;
   logic [CHW-1:0] win;
   logic           win_vld;
   logic [CHW-1:0] arb_base;
   logic [NCH-1:0] req;
   logic [NCH-1:0] owned;
   logic           terminal;
   logic           burst_go;
   logic           strobe;

   function automatic logic [CHW-1:0] slot(input logic [CHW-1:0] base, input int off);
      return CHW'((int'(base) + off) % NCH);
   endfunction

`ifdef DMAC_ROTATE_PRIO_EN
   logic [CHW-1:0] rot_ptr;

   // The channel just serviced drops to the bottom of the search order.
   always_ff @(posedge CLK) begin
      if (RST)
         rot_ptr <= '0;
      else if (state == S_UPDATE && state_nxt == S_IDLE)
         rot_ptr <= slot(ch, 1);
   end

   assign arb_base = rot_ptr;
`else
   assign arb_base = '0;
`endif

   always_comb begin
      req   = '0;
      owned = '0;
      for (int i = 0; i < NCH; i++) begin
         req[i]   = mode[i][4] & DREQ[i];
         owned[i] = (state != S_IDLE) && (ch == CHW'(i));
      end
   end

   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!win_vld && req[slot(arb_base, i)]) begin
            win     = slot(arb_base, i);
            win_vld = 1'b1;
         end
      end
   end

   assign terminal = (count[ch] == '0);
   assign burst_go = mode[ch][3] & DREQ[ch] & HLDA;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (win_vld) state_nxt = S_WAIT_HLDA;
         S_WAIT_HLDA: begin
            if (!DREQ[ch])  state_nxt = S_IDLE;
            else if (HLDA)  state_nxt = S_ADDR;
         end
         S_ADDR:      state_nxt = S_STROBE;
         S_STROBE:    if (RDY) state_nxt = S_UPDATE;
         S_UPDATE:    state_nxt = (!terminal && burst_go) ? S_ADDR : S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Strobes and EOP decode straight from state so a reset clears them on the same edge.
   assign strobe = (state == S_STROBE) && !mode[ch][1];
   assign MEMR   = strobe & ~mode[ch][0];
   assign IOW    = strobe & ~mode[ch][0];
   assign IOR    = strobe &  mode[ch][0];
   assign MEMW   = strobe &  mode[ch][0];
   assign EOP    = (state == S_UPDATE) && terminal;
   assign BUSY   = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         ch       <= '0;
         HLD      <= 1'b0;
         DACK     <= '0;
         Addrbus  <= '0;
         Data_out <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  ch  <= win;
                  HLD <= 1'b1;
               end
            end
            S_WAIT_HLDA: if (!DREQ[ch]) HLD <= 1'b0;
            S_ADDR: begin
               Addrbus <= addr[ch];
               DACK    <= NCH'(1) << ch;
            end
            S_STROBE: if (RDY) Data_out <= Data_in;
            S_UPDATE: begin
               if (state_nxt == S_IDLE) begin
                  HLD  <= 1'b0;
                  DACK <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // CPU writes never touch the channel the engine owns, so they cannot collide with the UPDATE step.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            mode[i]  <= '0;
            count[i] <= '0;
            addr[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (REGW && !owned[i]) begin
               if (REGSEL == 2'b11) begin
                  mode[i][4] <= 1'b0;
               end else if (CHSEL == CHW'(i)) begin
                  case (REGSEL)
                     2'b00:   mode[i]  <= Setup[4:0];
                     2'b01:   count[i] <= Setup;
                     default: addr[i]  <= Setup;
                  endcase
               end
            end
            if (owned[i] && state == S_UPDATE) begin
               addr[i]  <= mode[i][2] ? addr[i] - AW'(1) : addr[i] + AW'(1);
               count[i] <= count[i] - AW'(1);
               if (count[i] == '0) mode[i][4] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmac_multi.sv
// Self-checking bench for dmac_multi: cycle table, directed corner sequences, randomized transfer-level model.
`timescale 1ns/1ps
module tb_dmac_multi;
   localparam int NCH = 4, AW = 16, DW = 8, CHW = 2;

   logic           CLK = 1'b0;
   logic           RST, REGW, HLD, HLDA, RDY, MEMR, MEMW, IOR, IOW, EOP, BUSY;
   logic [CHW-1:0] CHSEL;
   logic [1:0]     REGSEL;
   logic [AW-1:0]  Setup, Addrbus;
   logic [NCH-1:0] DREQ, DACK;
   logic [DW-1:0]  Data_in, Data_out;

   int total = 0;
   int bad   = 0;

   dmac_multi #(.NCH(NCH), .AW(AW), .DW(DW), .CHW(CHW)) dut (
      .CLK(CLK), .RST(RST), .REGW(REGW), .CHSEL(CHSEL), .REGSEL(REGSEL), .Setup(Setup),
      .DREQ(DREQ), .DACK(DACK), .HLD(HLD), .HLDA(HLDA), .RDY(RDY),
      .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW), .EOP(EOP),
      .Addrbus(Addrbus), .Data_in(Data_in), .Data_out(Data_out), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit dreq, hlda, rdy; logic [7:0] din;
      bit hld, dack0, strb; logic [15:0] addr; bit eop, busy; logic [7:0] dout;
   } vec_t;
   vec_t tbl[$];

   typedef struct { int ch; logic [15:0] addr; bit dir; bit last; } xfer_t;
   xfer_t exp_q[$];
   xfer_t mon_e;
   bit         mon_on = 0, pend = 0, pend_last = 0;
   logic [7:0] pend_data = '0;

   // random scenario: per-channel programming
   bit         m_en[NCH], m_dir[NCH], m_dec[NCH], m_burst[NCH];
   int         m_cnt[NCH];
   logic [15:0] m_addr[NCH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] outs();
      return {HLD, DACK, MEMR, MEMW, IOR, IOW, EOP, BUSY, Addrbus, Data_out};
   endfunction

   function automatic int dack_ch(input logic [NCH-1:0] d);
      for (int i = 0; i < NCH; i++)
         if (d == (NCH'(1) << i)) return i;
      return -1;
   endfunction

   task automatic do_reset();
      RST = 1; REGW = 0; CHSEL = '0; REGSEL = '0; Setup = '0;
      DREQ = '0; HLDA = 0; RDY = 1; Data_in = '0;
      tick(); tick();
      RST = 0;
   endtask

   task automatic reg_write(input int c, input logic [1:0] sel, input logic [15:0] v);
      REGW = 1; CHSEL = CHW'(c); REGSEL = sel; Setup = v;
      tick();
      REGW = 0;
   endtask

   task automatic program_ch(input int c, input logic [15:0] md, input logic [15:0] cnt, input logic [15:0] a);
      reg_write(c, 2'b01, cnt);
      reg_write(c, 2'b10, a);
      reg_write(c, 2'b00, md);
   endtask

   task automatic wait_strobe(input string name, input int max);
      int n = 0;
      while (!(MEMR || IOR) && n < max) begin
         tick();
         n++;
      end
      if (!(MEMR || IOR)) begin
         total++; bad++;
         $display("FAIL %s timeout actual=no-strobe required=strobe", name);
      end
   endtask

   task automatic add_vec(input int dreq, input int hlda, input int rdy, input int din,
                          input int hld, input int dack0, input int strb, input int a,
                          input int eop, input int busy, input int dout);
      vec_t v;
      v.dreq = dreq[0]; v.hlda = hlda[0]; v.rdy = rdy[0]; v.din = din[7:0];
      v.hld = hld[0]; v.dack0 = dack0[0]; v.strb = strb[0]; v.addr = a[15:0];
      v.eop = eop[0]; v.busy = busy[0]; v.dout = dout[7:0];
      tbl.push_back(v);
   endtask

   // Expected transfer order from the channel programming: fixed or rotating priority, bursts run to the end.
   function automatic void build_model();
      int rem[NCH];
      logic [15:0] a[NCH];
      int ptr, pick, c, n;
      xfer_t x;
      for (int i = 0; i < NCH; i++) begin
         rem[i] = m_en[i] ? m_cnt[i] + 1 : 0;
         a[i]   = m_addr[i];
      end
      ptr = 0;
      forever begin
         pick = -1;
         for (int k = 0; k < NCH; k++) begin
`ifdef DMAC_ROTATE_PRIO_EN
            c = (ptr + k) % NCH;
`else
            c = k;
`endif
            if (pick < 0 && rem[c] > 0) pick = c;
         end
         if (pick < 0) break;
         n = m_burst[pick] ? rem[pick] : 1;
         for (int j = 0; j < n; j++) begin
            x.ch = pick; x.addr = a[pick]; x.dir = m_dir[pick]; x.last = (rem[pick] == 1);
            exp_q.push_back(x);
            a[pick] = m_dec[pick] ? a[pick] - 16'd1 : a[pick] + 16'd1;
            rem[pick]--;
         end
         ptr = (pick + 1) % NCH;
      end
   endfunction

   always @(negedge CLK) begin
      if (mon_on) begin
         if (pend) begin
            check("rnd_update", {Data_out, EOP}, {pend_data, pend_last});
            pend = 0;
         end else begin
            check("rnd_no_eop", EOP, 1'b0);
         end
         if ((MEMR || IOR) && RDY) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rnd_extra actual=ch%0d@%0h required=none", dack_ch(DACK), Addrbus);
            end else begin
               mon_e = exp_q.pop_front();
               check("rnd_xfer", {32'(dack_ch(DACK)), Addrbus, IOR, MEMW, MEMR, IOW},
                     {32'(mon_e.ch), mon_e.addr, mon_e.dir, mon_e.dir, !mon_e.dir, !mon_e.dir});
               pend = 1; pend_data = Data_in; pend_last = mon_e.last;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, rises, n;
      bit prev, strb_seen, eop_seen;
      logic [NCH-1:0] dack_e;
      logic [15:0]    addr_e;
      logic [19:0]    c_exp[4];

      // ---- cycle table: ch0 burst mem->IO, count 3, addr 0x0001
      add_vec(1,1,1,'h5A, 1,0,0,'h0000, 0,1,'h00);
      add_vec(1,1,1,'h5A, 1,0,0,'h0000, 0,1,'h00);
      add_vec(1,1,1,'h5A, 1,1,1,'h0001, 0,1,'h00);
      add_vec(1,1,1,'hA1, 1,1,0,'h0001, 0,1,'hA1);
      add_vec(1,1,1,'h5A, 1,1,0,'h0001, 0,1,'hA1);
      add_vec(1,1,1,'h5A, 1,1,1,'h0002, 0,1,'hA1);
      add_vec(1,1,1,'hB2, 1,1,0,'h0002, 0,1,'hB2);
      add_vec(1,1,1,'h5A, 1,1,0,'h0002, 0,1,'hB2);
      add_vec(1,1,1,'h5A, 1,1,1,'h0003, 0,1,'hB2);
      add_vec(1,1,1,'hC3, 1,1,0,'h0003, 0,1,'hC3);
      add_vec(1,1,1,'h5A, 1,1,0,'h0003, 0,1,'hC3);
      add_vec(1,1,1,'h5A, 1,1,1,'h0004, 0,1,'hC3);
      add_vec(1,1,1,'hD4, 1,1,0,'h0004, 1,1,'hD4);
      add_vec(1,1,1,'h5A, 0,0,0,'h0004, 0,0,'hD4);
      add_vec(1,1,1,'h5A, 0,0,0,'h0004, 0,0,'hD4);

      do_reset();
      check("reset", outs(), 64'h0);
      HLDA = 1;
      program_ch(0, 16'h0018, 16'd3, 16'h0001);
      for (int i = 0; i < tbl.size(); i++) begin
         DREQ = {3'b000, tbl[i].dreq}; HLDA = tbl[i].hlda; RDY = tbl[i].rdy; Data_in = tbl[i].din;
         tick();
         check($sformatf("vec%0d", i), outs(),
               {24'h0, tbl[i].hld, {3'b000, tbl[i].dack0}, tbl[i].strb, 1'b0, 1'b0, tbl[i].strb,
                tbl[i].eop, tbl[i].busy, tbl[i].addr, tbl[i].dout});
      end

      // ---- ch1 single IO->mem decrementing, wraps 0x0000 -> 0xFFFF
      do_reset(); HLDA = 1;
      program_ch(1, 16'h0015, 16'd1, 16'h0000);
      DREQ = 4'b0010;
      wait_strobe("a_x1", 20);
      check("a_x1", {Addrbus, IOR, MEMW, MEMR, IOW, DACK}, {16'h0000, 4'b1100, 4'b0010});
      tick(); check("a_eop1", EOP, 1'b0);
      tick(); check("a_release", {HLD, BUSY}, 2'b00);
      tick(); check("a_rereq", HLD, 1'b1);
      wait_strobe("a_x2", 20);
      check("a_x2", {Addrbus, IOR, MEMW, MEMR, IOW, DACK}, {16'hFFFF, 4'b1100, 4'b0010});
      tick(); check("a_eop2", EOP, 1'b1);
      tick(); tick(); tick();
      check("a_done", {HLD, BUSY, DACK}, 6'b0);

      // ---- burst with a 3-cycle RDY stall on the second transfer
      do_reset(); HLDA = 1;
      program_ch(0, 16'h0018, 16'd2, 16'h0100);
      DREQ = 4'b0001;
      wait_strobe("b_x1", 20);
      check("b_x1", Addrbus, 16'h0100);
      tick();
      wait_strobe("b_x2", 20);
      check("b_x2", Addrbus, 16'h0101);
      RDY = 0; hi = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (MEMR && IOW) hi++;
         check("b_hold_addr", Addrbus, 16'h0101);
      end
      RDY = 1;
      tick();
      check("b_len", hi, 4);
      check("b_upd", {MEMR, IOW, EOP}, 3'b000);
      wait_strobe("b_x3", 20);
      check("b_x3", Addrbus, 16'h0102);
      tick(); check("b_eop", EOP, 1'b1);

      // ---- ch0 and ch2 competing, single mode
      do_reset(); HLDA = 1;
      program_ch(0, 16'h0010, 16'd1, 16'h0200);
      program_ch(2, 16'h0010, 16'd1, 16'h0300);
`ifdef DMAC_ROTATE_PRIO_EN
      c_exp = '{{4'b0001, 16'h0200}, {4'b0100, 16'h0300}, {4'b0001, 16'h0201}, {4'b0100, 16'h0301}};
`else
      c_exp = '{{4'b0001, 16'h0200}, {4'b0001, 16'h0201}, {4'b0100, 16'h0300}, {4'b0100, 16'h0301}};
`endif
      DREQ = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         wait_strobe($sformatf("c_order%0d", k), 20);
         check($sformatf("c_order%0d", k), {DACK, Addrbus}, c_exp[k]);
         tick();
      end

      // ---- reset during STROBE of a burst
      do_reset(); HLDA = 1;
      program_ch(0, 16'h0018, 16'd5, 16'h0010);
      DREQ = 4'b0001;
      wait_strobe("d_x1", 20);
      RST = 1;
      tick();
      check("d_rst", outs(), 64'h0);
      RST = 0;
      tick(); tick(); tick(); tick();
      check("d_cleared", {HLD, BUSY}, 2'b00);

      // ---- writes while a burst owns ch0
      do_reset(); HLDA = 1;
      program_ch(0, 16'h0018, 16'd1, 16'h0040);
      DREQ = 4'b0001;
      wait_strobe("e_x1", 20);
      RDY = 0;
      reg_write(0, 2'b01, 16'h0005);
      program_ch(1, 16'h0010, 16'h0000, 16'h0077);
      RDY = 1;
      prev = 1; rises = 0; eop_seen = 0;
      for (int k = 0; k < 40 && !eop_seen; k++) begin
         tick();
         if ((MEMR || IOR) && !prev) rises++;
         prev = MEMR || IOR;
         if (EOP) eop_seen = 1;
      end
      check("e_ignored", {eop_seen, 8'(rises)}, {1'b1, 8'd1});
      tick();
      DREQ = 4'b0011;
      wait_strobe("e_idle_ch", 20);
      check("e_idle_ch", {DACK, Addrbus}, {4'b0010, 16'h0077});
      tick(); check("e_idle_eop", EOP, 1'b1);

      // ---- master clear on idle channels, then a verify transfer
      do_reset(); HLDA = 1;
      program_ch(3, 16'h0010, 16'd0, 16'h0000);
      reg_write(0, 2'b11, 16'h0000);
      program_ch(2, 16'h0012, 16'd0, 16'h0005);
      DREQ = 4'b1100;
      strb_seen = 0; eop_seen = 0; dack_e = '0; addr_e = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (MEMR || MEMW || IOR || IOW) strb_seen = 1;
         if (EOP && !eop_seen) begin
            eop_seen = 1; dack_e = DACK; addr_e = Addrbus;
         end
      end
      check("f_verify", {strb_seen, eop_seen, dack_e, addr_e}, {1'b0, 1'b1, 4'b0100, 16'h0005});
      check("f_mclr", {HLD, BUSY}, 2'b00);

      // ---- randomized channel programming against the transfer-order model
      for (int it = 0; it < 6; it++) begin
         do_reset(); HLDA = 1;
         for (int c = 0; c < NCH; c++) begin
            m_en[c]    = ($urandom_range(0, 3) != 0) || (c == it % NCH);
            m_dir[c]   = 1'($urandom_range(0, 1));
            m_dec[c]   = 1'($urandom_range(0, 1));
            m_burst[c] = 1'($urandom_range(0, 1));
            m_cnt[c]   = $urandom_range(0, 4);
            m_addr[c]  = 16'($urandom);
            if (m_en[c])
               program_ch(c, {11'b0, 1'b1, m_burst[c], m_dec[c], 1'b0, m_dir[c]}, 16'(m_cnt[c]), m_addr[c]);
         end
         build_model();
         mon_on = 1;
         DREQ = '1;
         n = 0;
         while ((exp_q.size() != 0 || pend || BUSY) && n < 600) begin
            RDY = ($urandom_range(0, 3) != 0);
            Data_in = 8'($urandom);
            tick();
            n++;
         end
         check($sformatf("rnd_drain%0d", it), {32'(exp_q.size()), BUSY}, 33'h0);
         mon_on = 0; pend = 0; RDY = 1; DREQ = '0;
         exp_q.delete();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
